// File: rtl/exu_decode_stage_pkg.sv
// Shared encodings and helpers for the registered decode stage.
package exu_decode_stage_pkg;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [1:0] RVC_Q0 = 2'b00;
   localparam logic [1:0] RVC_Q1 = 2'b01;
   localparam logic [1:0] RVC_Q2 = 2'b10;

   localparam logic [2:0] RVC_F3_LW    = 3'b010;
   localparam logic [2:0] RVC_F3_SW    = 3'b110;
   localparam logic [2:0] RVC_F3_ADDI  = 3'b000;
   localparam logic [2:0] RVC_F3_LI    = 3'b010;
   localparam logic [2:0] RVC_F3_J     = 3'b101;
   localparam logic [2:0] RVC_F3_BEQZ  = 3'b110;
   localparam logic [2:0] RVC_F3_BNEZ  = 3'b111;
   localparam logic [2:0] RVC_F3_MVADD = 3'b100;

   typedef struct packed {
      logic       rv32;
      logic       rs1en;
      logic       rs2en;
      logic       rdwen;
      logic [4:0] rs1_idx;
      logic [4:0] rs2_idx;
      logic [4:0] rd_idx;
      logic       illegal;
   } dec_info_t;

   // Compressed 3-bit register fields address x8..x15.
   function automatic logic [4:0] rvc_reg(input logic [2:0] r);
      return {2'b01, r};
   endfunction

endpackage

// File: rtl/exu_dec_comb.sv
// Combinational RV32I / RVC-subset decode into register read/write controls.
module exu_dec_comb
   import exu_decode_stage_pkg::*;
#(
   parameter bit RVC_EN = 1'b1
) (
   input  logic [31:0] instr,
   output dec_info_t   info
);

   logic       rv32;
   logic       rs1en;
   logic       rs2en;
   logic       rdwen;
   logic       illegal;
   logic [4:0] rs1_raw;
   logic [4:0] rs2_raw;
   logic [4:0] rd_raw;

   always_comb begin
      rs1en   = 1'b0;
      rs2en   = 1'b0;
      rdwen   = 1'b0;
      illegal = 1'b0;
      rs1_raw = instr[19:15];
      rs2_raw = instr[24:20];
      rd_raw  = instr[11:7];
      rv32    = (instr[1:0] == 2'b11) && (instr[4:2] != 3'b111);
      if (rv32) begin
         case (instr[6:2])
            OPC_LUI, OPC_AUIPC, OPC_JAL: rdwen = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
               rs1en = 1'b1;
               rdwen = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
               rs1en = 1'b1;
               rs2en = 1'b1;
            end
            OPC_OP: begin
               rs1en = 1'b1;
               rs2en = 1'b1;
               rdwen = 1'b1;
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
               if (instr[14:12] != 3'b000) begin
                  rs1en = 1'b1;
                  rdwen = 1'b1;
               end
            end
            default: illegal = 1'b1;
         endcase
      end else if (RVC_EN && (instr[1:0] != 2'b11)) begin
         // All-zero halfword falls into the Q0/000 default and is illegal.
         case ({instr[1:0], instr[15:13]})
            {RVC_Q0, RVC_F3_LW}: begin
               rs1en   = 1'b1;
               rdwen   = 1'b1;
               rs1_raw = rvc_reg(instr[9:7]);
               rd_raw  = rvc_reg(instr[4:2]);
            end
            {RVC_Q0, RVC_F3_SW}: begin
               rs1en   = 1'b1;
               rs2en   = 1'b1;
               rs1_raw = rvc_reg(instr[9:7]);
               rs2_raw = rvc_reg(instr[4:2]);
            end
            {RVC_Q1, RVC_F3_ADDI}: begin
               rs1en   = 1'b1;
               rdwen   = 1'b1;
               rs1_raw = instr[11:7];
            end
            {RVC_Q1, RVC_F3_LI}: rdwen = 1'b1;
            {RVC_Q1, RVC_F3_J}: ;
            {RVC_Q1, RVC_F3_BEQZ}, {RVC_Q1, RVC_F3_BNEZ}: begin
               rs1en   = 1'b1;
               rs1_raw = rvc_reg(instr[9:7]);
            end
            {RVC_Q2, RVC_F3_MVADD}: begin
               rs2en   = 1'b1;
               rdwen   = 1'b1;
               rs2_raw = instr[6:2];
               rs1en   = instr[12];
               rs1_raw = instr[11:7];
            end
            default: illegal = 1'b1;
         endcase
      end else begin
         illegal = 1'b1;
      end
   end

   assign info.rv32    = rv32;
   assign info.rs1en   = rs1en;
   assign info.rs2en   = rs2en;
   assign info.rdwen   = rdwen;
   assign info.rs1_idx = rs1en ? rs1_raw : 5'd0;
   assign info.rs2_idx = rs2en ? rs2_raw : 5'd0;
   assign info.rd_idx  = rdwen ? rd_raw : 5'd0;
   assign info.illegal = illegal;

endmodule

// File: rtl/exu_decode_stage.sv
// Registered, handshaked decode stage with a per-register write scoreboard
// that stalls the IFU on RAW/WAW hazards against in-flight writes.
module exu_decode_stage
   import exu_decode_stage_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter bit RVC_EN = 1'b1,
   parameter bit SB_EN  = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            ifu_valid_i,
   output logic            ifu_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [PC_W-1:0] pc_i,
   output logic            dec_valid_o,
   input  logic            dec_ready_i,
   output logic [PC_W-1:0] dec_pc_o,
   output logic [31:0]     dec_instr_o,
   output logic            dec_rv32_o,
   output logic            dec_rs1en_o,
   output logic            dec_rs2en_o,
   output logic            dec_rdwen_o,
   output logic [4:0]      dec_rs1_idx_o,
   output logic [4:0]      dec_rs2_idx_o,
   output logic [4:0]      dec_rd_idx_o,
   output logic            dec_rs1x0_o,
   output logic            dec_rs2x0_o,
   output logic            dec_illegal_o,
   input  logic            wb_valid_i,
   input  logic [4:0]      wb_rd_idx_i
);

   dec_info_t       in_info;
   dec_info_t       out_info;
   logic            valid_q;
   logic [PC_W-1:0] pc_q;
   logic [31:0]     instr_q;
   logic [31:0]     sb_q;
   logic            hz;
   logic            out_hs;
   logic            accept;

   exu_dec_comb #(.RVC_EN(RVC_EN)) u_dec (
      .instr (instr_i),
      .info  (in_info)
   );

   assign hz = ifu_valid_i && ((in_info.rs1en && sb_q[in_info.rs1_idx]) ||
                               (in_info.rs2en && sb_q[in_info.rs2_idx]) ||
                               (in_info.rdwen && sb_q[in_info.rd_idx]));

   assign out_hs      = valid_q && dec_ready_i;
   assign ifu_ready_o = (!valid_q || dec_ready_i) && !hz && !flush_i;
   assign accept      = ifu_valid_i && ifu_ready_o;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q  <= 1'b0;
         pc_q     <= '0;
         instr_q  <= '0;
         out_info <= '0;
      end else begin
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
         end else if (out_hs) begin
            valid_q <= 1'b0;
         end
         if (accept) begin
            pc_q     <= pc_i;
            instr_q  <= instr_i;
            out_info <= in_info;
         end
      end
   end

   // A flush does not touch the scoreboard: older writebacks still retire.
   generate
      if (SB_EN) begin : g_sb
         logic [31:0] sb_next;

         always_comb begin
            sb_next = sb_q;
            if (wb_valid_i) begin
               sb_next[wb_rd_idx_i] = 1'b0;
            end
            if (out_hs && out_info.rdwen && (out_info.rd_idx != 5'd0)) begin
               sb_next[out_info.rd_idx] = 1'b1;
            end
            sb_next[0] = 1'b0;
         end

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               sb_q <= '0;
            end else begin
               sb_q <= sb_next;
            end
         end
      end else begin : g_no_sb
         assign sb_q = '0;
      end
   endgenerate

   assign dec_valid_o   = valid_q;
   assign dec_pc_o      = pc_q;
   assign dec_instr_o   = instr_q;
   assign dec_rv32_o    = out_info.rv32;
   assign dec_rs1en_o   = out_info.rs1en;
   assign dec_rs2en_o   = out_info.rs2en;
   assign dec_rdwen_o   = out_info.rdwen;
   assign dec_rs1_idx_o = out_info.rs1_idx;
   assign dec_rs2_idx_o = out_info.rs2_idx;
   assign dec_rd_idx_o  = out_info.rd_idx;
   assign dec_rs1x0_o   = out_info.rs1en && (out_info.rs1_idx == 5'd0);
   assign dec_rs2x0_o   = out_info.rs2en && (out_info.rs2_idx == 5'd0);
   assign dec_illegal_o = out_info.illegal;

endmodule

// File: tb/tb_exu_decode_stage.sv
// Scoreboard bench for exu_decode_stage: a driver models acceptance and the
// register scoreboard, a negedge monitor pops expected entries on handshake.
module tb_exu_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        rv32;
      logic        rs1en;
      logic        rs2en;
      logic        rdwen;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        flush_i;
   logic        ifu_valid_i;
   logic        ifu_ready_o;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic        dec_valid_o;
   logic        dec_ready_i;
   logic [31:0] dec_pc_o;
   logic [31:0] dec_instr_o;
   logic        dec_rv32_o;
   logic        dec_rs1en_o;
   logic        dec_rs2en_o;
   logic        dec_rdwen_o;
   logic [4:0]  dec_rs1_idx_o;
   logic [4:0]  dec_rs2_idx_o;
   logic [4:0]  dec_rd_idx_o;
   logic        dec_rs1x0_o;
   logic        dec_rs2x0_o;
   logic        dec_illegal_o;
   logic        wb_valid_i;
   logic [4:0]  wb_rd_idx_i;

   logic        n_valid;
   logic        n_ready;
   logic [31:0] n_instr;
   logic        n_dec_valid;
   logic [31:0] n_dec_pc;
   logic [31:0] n_dec_instr;
   logic        n_rv32;
   logic        n_rs1en;
   logic        n_rs2en;
   logic        n_rdwen;
   logic [4:0]  n_rs1;
   logic [4:0]  n_rs2;
   logic [4:0]  n_rd;
   logic        n_rs1x0;
   logic        n_rs2x0;
   logic        n_illegal;

   int          nChecks = 0;
   int          nPass   = 0;
   exp_t        expQ[$];
   exp_t        monE;
   bit [31:0]   busy;
   bit          mValid;
   bit [4:0]    mRd;
   bit          mRdwen;

   always #5 clk_i = ~clk_i;

   exu_decode_stage dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
      .ifu_valid_i(ifu_valid_i), .ifu_ready_o(ifu_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
      .dec_pc_o(dec_pc_o), .dec_instr_o(dec_instr_o), .dec_rv32_o(dec_rv32_o),
      .dec_rs1en_o(dec_rs1en_o), .dec_rs2en_o(dec_rs2en_o), .dec_rdwen_o(dec_rdwen_o),
      .dec_rs1_idx_o(dec_rs1_idx_o), .dec_rs2_idx_o(dec_rs2_idx_o), .dec_rd_idx_o(dec_rd_idx_o),
      .dec_rs1x0_o(dec_rs1x0_o), .dec_rs2x0_o(dec_rs2x0_o), .dec_illegal_o(dec_illegal_o),
      .wb_valid_i(wb_valid_i), .wb_rd_idx_i(wb_rd_idx_i)
   );

   exu_decode_stage #(.PC_W(32), .RVC_EN(1'b0), .SB_EN(1'b1)) dut_norvc (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(1'b0),
      .ifu_valid_i(n_valid), .ifu_ready_o(),
      .instr_i(n_instr), .pc_i(32'h0),
      .dec_valid_o(n_dec_valid), .dec_ready_i(n_ready),
      .dec_pc_o(n_dec_pc), .dec_instr_o(n_dec_instr), .dec_rv32_o(n_rv32),
      .dec_rs1en_o(n_rs1en), .dec_rs2en_o(n_rs2en), .dec_rdwen_o(n_rdwen),
      .dec_rs1_idx_o(n_rs1), .dec_rs2_idx_o(n_rs2), .dec_rd_idx_o(n_rd),
      .dec_rs1x0_o(n_rs1x0), .dec_rs2x0_o(n_rs2x0), .dec_illegal_o(n_illegal),
      .wb_valid_i(1'b0), .wb_rd_idx_i(5'd0)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the ISA role table.
   function automatic exp_t refDecode(input logic [31:0] ins, input bit rvcEn);
      exp_t       e;
      bit         u1, u2, ud;
      logic [4:0] s1, s2, d;
      logic [2:0] f3;
      e  = '0;
      u1 = 0; u2 = 0; ud = 0;
      s1 = ins[19:15]; s2 = ins[24:20]; d = ins[11:7];
      f3 = ins[15:13];
      e.rv32 = (ins[1:0] == 2'b11) && (ins[4:2] != 3'b111);
      if (e.rv32) begin
         case (ins[6:2])
            5'h0D, 5'h05, 5'h1B: ud = 1;
            5'h19, 5'h00, 5'h04: begin u1 = 1; ud = 1; end
            5'h18, 5'h08:        begin u1 = 1; u2 = 1; end
            5'h0C:               begin u1 = 1; u2 = 1; ud = 1; end
            5'h03:               ;
            5'h1C:               if (ins[14:12] != 0) begin u1 = 1; ud = 1; end
            default:             e.illegal = 1;
         endcase
      end else if (rvcEn && ins[1:0] != 2'b11) begin
         if (ins[1:0] == 0 && f3 == 2) begin
            u1 = 1; ud = 1; s1 = 5'(8 + ins[9:7]); d = 5'(8 + ins[4:2]);
         end else if (ins[1:0] == 0 && f3 == 6) begin
            u1 = 1; u2 = 1; s1 = 5'(8 + ins[9:7]); s2 = 5'(8 + ins[4:2]);
         end else if (ins[1:0] == 1 && f3 == 0) begin
            u1 = 1; ud = 1; s1 = ins[11:7];
         end else if (ins[1:0] == 1 && f3 == 2) begin
            ud = 1;
         end else if (ins[1:0] == 1 && f3 == 5) begin
            ;
         end else if (ins[1:0] == 1 && (f3 == 6 || f3 == 7)) begin
            u1 = 1; s1 = 5'(8 + ins[9:7]);
         end else if (ins[1:0] == 2 && f3 == 4) begin
            u2 = 1; ud = 1; s2 = ins[6:2];
            if (ins[12]) begin u1 = 1; s1 = ins[11:7]; end
         end else begin
            e.illegal = 1;
         end
      end else begin
         e.illegal = 1;
      end
      e.rs1en = u1; e.rs2en = u2; e.rdwen = ud;
      e.rs1 = u1 ? s1 : 5'd0;
      e.rs2 = u2 ? s2 : 5'd0;
      e.rd  = ud ? d  : 5'd0;
      return e;
   endfunction

   function automatic logic [31:0] genInstr();
      logic [31:0] r;
      logic [4:0]  sel;
      int          k;
      r = $urandom;
      k = $urandom_range(0, 9);
      if (k < 6) begin
         case ($urandom_range(0, 13))
            0: sel = 5'h0D;  1: sel = 5'h05;  2: sel = 5'h1B;  3: sel = 5'h19;
            4: sel = 5'h00;  5: sel = 5'h04;  6: sel = 5'h18;  7: sel = 5'h08;
            8: sel = 5'h0C;  9: sel = 5'h03; 10: sel = 5'h1C; 11: sel = 5'h0B;
            12: sel = 5'h14; default: sel = 5'h1F;
         endcase
         r[1:0] = 2'b11; r[6:2] = sel;
         r[11:10] = 2'b00; r[19:18] = 2'b00; r[24:23] = 2'b00;
      end else if (k < 9) begin
         case ($urandom_range(0, 9))
            0: sel = 5'b00_010; 1: sel = 5'b00_110; 2: sel = 5'b01_000; 3: sel = 5'b01_010;
            4: sel = 5'b01_101; 5: sel = 5'b01_110; 6: sel = 5'b01_111; 7: sel = 5'b10_100;
            8: sel = 5'b00_000; default: sel = 5'b10_010;
         endcase
         r[1:0] = sel[4:3]; r[15:13] = sel[2:0];
         r[11:10] = 2'b00; r[6:5] = 2'b00;
         if ($urandom_range(0, 9) == 0) r[15:0] = 16'h0000;
      end
      return r;
   endfunction

   // One clock cycle: drive, check ready/valid against the model, advance the model.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                                input logic rdy, input logic wbv, input logic [4:0] wbr,
                                input logic fl);
      exp_t e;
      bit   hz, expReady, hs;
      ifu_valid_i = v; instr_i = ins; pc_i = p; dec_ready_i = rdy;
      wb_valid_i = wbv; wb_rd_idx_i = wbr; flush_i = fl;
      #1;
      e  = refDecode(ins, 1'b1);
      hz = v && ((e.rs1en && busy[e.rs1]) || (e.rs2en && busy[e.rs2]) || (e.rdwen && busy[e.rd]));
      expReady = (!mValid || rdy) && !hz && !fl;
      checkOutput("ifu_ready", ifu_ready_o, expReady);
      checkOutput("dec_valid", dec_valid_o, mValid);
      hs = mValid && rdy;
      if (wbv) busy[wbr] = 1'b0;
      if (hs && mRdwen && mRd != 0) busy[mRd] = 1'b1;
      busy[0] = 1'b0;
      if (fl && mValid && !hs && expQ.size() > 0) void'(expQ.pop_back());
      if (v && expReady) begin
         e.pc = p; e.instr = ins;
         expQ.push_back(e);
         mValid = 1; mRd = e.rd; mRdwen = e.rdwen;
      end else if (fl || hs) begin
         mValid = 0;
      end
      @(posedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      if (rst_n_i && dec_valid_o && dec_ready_i) begin
         if (expQ.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected_entry: got pc %0h expected no entry", dec_pc_o);
         end else begin
            monE = expQ.pop_front();
            checkOutput("out_pc", dec_pc_o, monE.pc);
            checkOutput("out_instr", dec_instr_o, monE.instr);
            checkOutput("out_ctrl",
               {dec_rv32_o, dec_rs1en_o, dec_rs2en_o, dec_rdwen_o, dec_rs1_idx_o, dec_rs2_idx_o,
                dec_rd_idx_o, dec_illegal_o, dec_rs1x0_o, dec_rs2x0_o},
               {monE.rv32, monE.rs1en, monE.rs2en, monE.rdwen, monE.rs1, monE.rs2, monE.rd,
                monE.illegal, monE.rs1en && monE.rs1 == 0, monE.rs2en && monE.rs2 == 0});
         end
      end
   end

   initial begin
      rst_n_i = 0; flush_i = 0; ifu_valid_i = 0; instr_i = 0; pc_i = 0; dec_ready_i = 0;
      wb_valid_i = 0; wb_rd_idx_i = 0;
      n_valid = 0; n_ready = 1; n_instr = 0;
      busy = '0; mValid = 0; mRd = 0; mRdwen = 0;
      #1;
      checkOutput("reset_valid", dec_valid_o, 0);
      checkOutput("reset_payload", {dec_pc_o, dec_instr_o}, 64'h0);
      checkOutput("reset_ctrl", {dec_rs1en_o, dec_rs2en_o, dec_rdwen_o, dec_illegal_o}, 0);
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1;
      @(posedge clk_i);
      #1;

      // ADD x3,x1,x2 then a dependent ADD x4,x3,x1
      applyStimulus(1, 32'h002081B3, 32'h100, 1, 0, 0, 0);
      checkOutput("add_fields", {dec_rv32_o, dec_rs1en_o, dec_rs2en_o, dec_rdwen_o,
                                 dec_rs1_idx_o, dec_rs2_idx_o, dec_rd_idx_o},
                  {4'b1111, 5'd1, 5'd2, 5'd3});
      applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);
      applyStimulus(1, 32'h00118233, 32'h104, 1, 0, 0, 0);
      checkOutput("raw_stall", ifu_ready_o, 0);
      applyStimulus(1, 32'h00118233, 32'h104, 1, 1, 5'd3, 0);
      applyStimulus(1, 32'h00118233, 32'h104, 1, 0, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);

      // C.LW x9,0(x10) on both RVC-enabled and RVC-disabled stages
      n_valid = 1; n_instr = 32'h00004104;
      applyStimulus(1, 32'h00004104, 32'h200, 1, 0, 0, 0);
      n_valid = 0;
      checkOutput("clw_fields", {dec_rv32_o, dec_rs1en_o, dec_rs2en_o, dec_rdwen_o,
                                 dec_rs1_idx_o, dec_rd_idx_o}, {4'b0101, 5'd10, 5'd9});
      checkOutput("norvc_illegal", {n_dec_valid, n_illegal, n_rs1en, n_rs2en, n_rdwen, n_rv32},
                  6'b110000);

      // Hold for three cycles, then release
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 32'h00100393, 32'h300, 0, 0, 0, 0);
         checkOutput("hold_payload", {dec_pc_o, dec_instr_o}, {32'h200, 32'h00004104});
      end
      applyStimulus(1, 32'h00100393, 32'h300, 1, 0, 0, 0);

      // Flush while holding ADDI x7; x4 stays busy, x7 never became busy
      applyStimulus(1, 32'h00038433, 32'h304, 0, 0, 0, 1);
      checkOutput("flush_valid", dec_valid_o, 0);
      applyStimulus(1, 32'h000204B3, 32'h308, 1, 0, 0, 0);
      applyStimulus(1, 32'h00038433, 32'h30C, 1, 0, 0, 0);

      // Same-cycle set and clear of x5: set wins
      applyStimulus(1, 32'h00100293, 32'h400, 1, 0, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 1, 1, 5'd5, 0);
      applyStimulus(1, 32'h00528333, 32'h404, 1, 0, 0, 0);
      checkOutput("set_wins", ifu_ready_o, 0);
      applyStimulus(1, 32'h00528333, 32'h404, 1, 1, 5'd5, 0);
      applyStimulus(1, 32'h00528333, 32'h404, 1, 0, 0, 0);

      // All-zero word, ADDI x0,x0,0, then a reader of x0
      applyStimulus(1, 32'h00000000, 32'h500, 1, 0, 0, 0);
      checkOutput("zero_illegal", {dec_illegal_o, dec_rs1en_o, dec_rs2en_o, dec_rdwen_o}, 4'b1000);
      applyStimulus(1, 32'h00000013, 32'h504, 1, 0, 0, 0);
      checkOutput("addi_x0", {dec_rdwen_o, dec_rd_idx_o, dec_rs1x0_o}, {1'b1, 5'd0, 1'b1});
      applyStimulus(1, 32'h000000B3, 32'h508, 1, 0, 0, 0);

      for (int i = 0; i < 500; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, genInstr(), $urandom,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                       5'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
      end

      for (int i = 0; i < 32; i++) applyStimulus(0, 32'h0, 32'h0, 1, 1, 5'(i), 0);
      checkOutput("queue_drained", expQ.size(), 0);

      // Asynchronous reset with a held entry and a busy register
      applyStimulus(1, 32'h002081B3, 32'h600, 1, 0, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);
      applyStimulus(1, 32'h00100393, 32'h604, 0, 0, 0, 0);
      ifu_valid_i = 0;
      rst_n_i = 0;
      #1;
      checkOutput("async_reset", {dec_valid_o, dec_pc_o, dec_instr_o}, 65'h0);
      expQ.delete(); busy = '0; mValid = 0;
      @(posedge clk_i);
      #1 rst_n_i = 1;
      @(posedge clk_i);
      #1;
      applyStimulus(1, 32'h00118233, 32'h700, 1, 0, 0, 0);
      applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0);
      checkOutput("final_queue", expQ.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
